// File: rtl/mem_pkg.sv
// Shared types and constants for the memory stage: FSM states, resultSrc
// encodings, timeout default and the M/W register payload.
package mem_pkg;

   typedef enum logic [0:0] {
      ST_IDLE   = 1'b0,
      ST_ACCESS = 1'b1
   } state_t;

   localparam logic [1:0] RES_ALU = 2'b00;
   localparam logic [1:0] RES_MEM = 2'b01;
   localparam logic [1:0] RES_PC  = 2'b10;

   localparam int TIMEOUT_DEF = 15;

   typedef struct packed {
      logic        regWrite;
      logic [1:0]  resultSrc;
      logic [15:0] aluRes;
      logic [15:0] pcPlus2;
      logic [3:0]  rd;
   } mw_t;

endpackage

// File: rtl/memory_stage_if.sv
// Data-memory request/response bus between the memory stage and its memory.
interface memory_stage_if;
   logic        dmem_req;
   logic        dmem_we;
   logic [15:0] dmem_addr;
   logic [15:0] dmem_wdata;
   logic [15:0] dmem_rdata;
   logic        dmem_ready;

   modport master (output dmem_req, dmem_we, dmem_addr, dmem_wdata,
                   input  dmem_rdata, dmem_ready);
   modport slave  (input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
                   output dmem_rdata, dmem_ready);
endinterface

// File: rtl/mw_reg.sv
// M/W pipeline register: load captures the whole payload, bubble only kills
// regWrite; readData is captured separately so stores leave it untouched.
module mw_reg
   import mem_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        load_i,
   input  logic        bubble_i,
   input  logic        rd_en_i,
   input  mw_t         mw_i,
   input  logic [15:0] rdata_i,
   output mw_t         mw_o,
   output logic [15:0] rdata_o
);

   mw_t         mw_q, mw_d;
   logic [15:0] rdata_q, rdata_d;

   always_comb begin
      mw_d    = mw_q;
      rdata_d = rdata_q;
      if (load_i) begin
         mw_d = mw_i;
         if (rd_en_i) rdata_d = rdata_i;
      end else if (bubble_i) begin
         mw_d.regWrite = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mw_q    <= '0;
         rdata_q <= '0;
      end else begin
         mw_q    <= mw_d;
         rdata_q <= rdata_d;
      end
   end

   assign mw_o    = mw_q;
   assign rdata_o = rdata_q;

endmodule

// File: rtl/memory_stage.sv
// Memory pipeline stage: IDLE/ACCESS handshake with data memory, stall
// generation, timeout and misalignment faults, feeding the M/W register.
module memory_stage
   import mem_pkg::*;
#(
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           regWriteM,
   input  logic           memWriteM,
   input  logic [1:0]     resultSrcM,
   input  logic [15:0]    PCPlus2M,
   input  logic [15:0]    aluResM,
   input  logic [15:0]    writeDataM,
   input  logic [3:0]     RdM,
   memory_stage_if.master dmem,
   output logic           stallM,
   output logic           memFaultW,
   output logic           regWriteW,
   output logic [1:0]     resultSrcW,
   output logic [15:0]    aluResW,
   output logic [15:0]    readDataW,
   output logic [15:0]    PCPlus2W,
   output logic [3:0]     RdW
);

   localparam int CW = ($clog2(TIMEOUT) > 4) ? $clog2(TIMEOUT) : 4;
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          fault_q, fault_d;

   logic is_load, mem_op, misaligned, in_acc, done, timeout, load_w;
   mw_t  mw_in, mw_out;

   assign is_load    = (resultSrcM == RES_MEM);
   assign mem_op     = memWriteM | is_load;
   assign misaligned = mem_op & aluResM[0];
   assign in_acc     = (state_q == ST_ACCESS);

   // Ready wins over timeout when both land on the same cycle.
   assign done    = in_acc & dmem.dmem_ready;
   assign timeout = in_acc & ~dmem.dmem_ready & (cnt_q == CNT_LAST);

   assign stallM = (~in_acc & mem_op & ~misaligned) |
                   (in_acc & ~dmem.dmem_ready & ~timeout);

   // Anything that does not load M/W (stall, misalign, timeout) is a bubble.
   assign load_w = (~in_acc & ~mem_op) | done;

   assign dmem.dmem_req   = in_acc;
   assign dmem.dmem_we    = in_acc & memWriteM;
   assign dmem.dmem_addr  = in_acc ? aluResM    : '0;
   assign dmem.dmem_wdata = in_acc ? writeDataM : '0;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      fault_d = (~in_acc & misaligned) | timeout;
      case (state_q)
         ST_IDLE: begin
            if (mem_op & ~misaligned) begin
               state_d = ST_ACCESS;
               cnt_d   = '0;
            end
         end
         ST_ACCESS: begin
            if (done | timeout) state_d = ST_IDLE;
            else                cnt_d   = cnt_q + CW'(1);
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         fault_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         fault_q <= fault_d;
      end
   end

   assign mw_in = '{regWrite: regWriteM, resultSrc: resultSrcM, aluRes: aluResM,
                    pcPlus2: PCPlus2M, rd: RdM};

   mw_reg u_mw_reg (
      .clk      (clk),
      .rst      (rst),
      .load_i   (load_w),
      .bubble_i (~load_w),
      .rd_en_i  (is_load & ~memWriteM),
      .mw_i     (mw_in),
      .rdata_i  (dmem.dmem_rdata),
      .mw_o     (mw_out),
      .rdata_o  (readDataW)
   );

   assign memFaultW  = fault_q;
   assign regWriteW  = mw_out.regWrite;
   assign resultSrcW = mw_out.resultSrc;
   assign aluResW    = mw_out.aluRes;
   assign PCPlus2W   = mw_out.pcPlus2;
   assign RdW        = mw_out.rd;

endmodule

// File: tb/tb_memory_stage.sv
// Self-checking bench for memory_stage: directed scenarios plus random ops
// against a per-instruction model of stall length, bus activity and W state.
module tb_memory_stage;

   localparam int TO = 15;

   logic        clk = 1'b0;
   logic        rst;
   logic        regWriteM, memWriteM;
   logic [1:0]  resultSrcM;
   logic [15:0] PCPlus2M, aluResM, writeDataM;
   logic [3:0]  RdM;
   logic        stallM, memFaultW, regWriteW;
   logic [1:0]  resultSrcW;
   logic [15:0] aluResW, readDataW, PCPlus2W;
   logic [3:0]  RdW;

   int total = 0;
   int bad   = 0;

   // Expected architectural contents of the M/W register
   logic        m_rw;
   logic [1:0]  m_src;
   logic [15:0] m_alu, m_rdat, m_pc;
   logic [3:0]  m_rd;

   memory_stage_if dif();

   memory_stage #(.TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst),
      .regWriteM(regWriteM), .memWriteM(memWriteM), .resultSrcM(resultSrcM),
      .PCPlus2M(PCPlus2M), .aluResM(aluResM), .writeDataM(writeDataM), .RdM(RdM),
      .dmem(dif),
      .stallM(stallM), .memFaultW(memFaultW), .regWriteW(regWriteW),
      .resultSrcW(resultSrcW), .aluResW(aluResW), .readDataW(readDataW),
      .PCPlus2W(PCPlus2W), .RdW(RdW)
   );

   always #5 clk = ~clk;

   // One instruction, entered at a negedge. d = ACCESS cycles before ready.
   task automatic run_op(input string nm, input logic rw, input logic mw,
                         input logic [1:0] src, input logic [15:0] alu,
                         input logic [15:0] wd, input logic [15:0] pc,
                         input logic [3:0] rd, input int d,
                         input logic [15:0] rdat, input logic idle_rdy);
      logic memop, mis, ok;
      int nstall;
      logic [33:0] exp_bus;
      memop = mw || (src == 2'b01);
      mis   = memop && alu[0];
      ok    = !memop || (!mis && d <= TO - 1);
      if (!memop || mis)  nstall = 0;
      else if (d <= TO-1) nstall = d + 1;
      else                nstall = TO;
      regWriteM = rw; memWriteM = mw; resultSrcM = src; aluResM = alu;
      writeDataM = wd; PCPlus2M = pc; RdM = rd; dif.dmem_rdata = rdat;
      for (int k = 0; k <= nstall; k++) begin
         dif.dmem_ready = (k == 0) ? idle_rdy : (k - 1 == d);
         #1;
         total++;
         if (stallM !== (k < nstall)) begin
            bad++; $display("FAIL %s stallM cyc%0d got=%b exp=%b", nm, k, stallM, (k < nstall));
         end
         exp_bus = (memop && !mis && k >= 1) ? {1'b1, mw, alu, wd} : 34'b0;
         total++;
         if ({dif.dmem_req, dif.dmem_we, dif.dmem_addr, dif.dmem_wdata} !== exp_bus) begin
            bad++; $display("FAIL %s bus cyc%0d got=%h exp=%h", nm, k,
               {dif.dmem_req, dif.dmem_we, dif.dmem_addr, dif.dmem_wdata}, exp_bus);
         end
         @(posedge clk); @(negedge clk);
         if (k < nstall) begin
            m_rw = 1'b0;
            total++;
            if ({regWriteW, resultSrcW, aluResW, readDataW, PCPlus2W, RdW} !==
                {m_rw, m_src, m_alu, m_rdat, m_pc, m_rd} || memFaultW !== 1'b0) begin
               bad++; $display("FAIL %s bubble cyc%0d got=%h/%b exp=%h/0", nm, k,
                  {regWriteW, resultSrcW, aluResW, readDataW, PCPlus2W, RdW}, memFaultW,
                  {m_rw, m_src, m_alu, m_rdat, m_pc, m_rd});
            end
         end
      end
      if (ok) begin
         m_rw = rw; m_src = src; m_alu = alu; m_pc = pc; m_rd = rd;
         if (memop && !mw) m_rdat = rdat;
      end else begin
         m_rw = 1'b0;
      end
      total++;
      if ({regWriteW, resultSrcW, aluResW, readDataW, PCPlus2W, RdW} !==
          {m_rw, m_src, m_alu, m_rdat, m_pc, m_rd}) begin
         bad++; $display("FAIL %s wregs got=%h exp=%h", nm,
            {regWriteW, resultSrcW, aluResW, readDataW, PCPlus2W, RdW},
            {m_rw, m_src, m_alu, m_rdat, m_pc, m_rd});
      end
      total++;
      if (memFaultW !== !ok) begin
         bad++; $display("FAIL %s fault got=%b exp=%b", nm, memFaultW, !ok);
      end
      dif.dmem_ready = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      regWriteM = 1'b0; memWriteM = 1'b0; resultSrcM = 2'b00;
      aluResM = 16'h0; writeDataM = 16'h0; PCPlus2M = 16'h0; RdM = 4'h0;
      dif.dmem_ready = 1'b0; dif.dmem_rdata = 16'h0;
      #1 rst = 1'b0;
      #2;
      m_rw = 1'b0; m_src = 2'b00; m_alu = 16'h0; m_rdat = 16'h0; m_pc = 16'h0; m_rd = 4'h0;
      total++;
      if ({regWriteW, resultSrcW, aluResW, readDataW, PCPlus2W, RdW, memFaultW} !== 56'h0) begin
         bad++; $display("FAIL reset_w got=%h exp=0",
            {regWriteW, resultSrcW, aluResW, readDataW, PCPlus2W, RdW, memFaultW});
      end
      total++;
      if ({dif.dmem_req, dif.dmem_we, dif.dmem_addr, dif.dmem_wdata, stallM} !== 35'h0) begin
         bad++; $display("FAIL reset_bus got=%h exp=0",
            {dif.dmem_req, dif.dmem_we, dif.dmem_addr, dif.dmem_wdata, stallM});
      end
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_alu;
      run_op("alu_1f", 1'b1, 1'b0, 2'b00, 16'h001F, 16'h5555, 16'h0102, 4'd2, 0, 16'h0, 1'b0);
      run_op("pc2", 1'b1, 1'b0, 2'b10, 16'h0033, 16'h0, 16'h0204, 4'd7, 0, 16'h0, 1'b1);
      run_op("reserved", 1'b1, 1'b0, 2'b11, 16'h0045, 16'h0, 16'h0206, 4'd9, 0, 16'hDEAD, 1'b1);
   endtask

   task automatic test_load;
      run_op("load_wait3", 1'b1, 1'b0, 2'b01, 16'h0040, 16'h0, 16'h0300, 4'd5, 3, 16'hBEEF, 1'b0);
      run_op("load_idle_rdy", 1'b1, 1'b0, 2'b01, 16'h0042, 16'h0, 16'h0302, 4'd6, 0, 16'hCAFE, 1'b1);
      run_op("load_last", 1'b1, 1'b0, 2'b01, 16'h0044, 16'h0, 16'h0304, 4'd8, TO-1, 16'h7777, 1'b0);
   endtask

   task automatic test_store;
      run_op("store", 1'b0, 1'b1, 2'b00, 16'h0010, 16'h1234, 16'h0400, 4'd3, 0, 16'hAAAA, 1'b0);
      run_op("store_src01", 1'b0, 1'b1, 2'b01, 16'h0012, 16'h4321, 16'h0402, 4'd4, 2, 16'hBBBB, 1'b0);
   endtask

   task automatic test_timeout;
      run_op("timeout", 1'b1, 1'b0, 2'b01, 16'h0020, 16'h0, 16'h0500, 4'd1, 100, 16'h9999, 1'b0);
      run_op("after_to", 1'b1, 1'b0, 2'b00, 16'h0022, 16'h0, 16'h0502, 4'd1, 0, 16'h0, 1'b0);
   endtask

   task automatic test_misaligned;
      run_op("misaligned", 1'b1, 1'b0, 2'b01, 16'h0011, 16'h0, 16'h0600, 4'd2, 0, 16'h1111, 1'b1);
      run_op("mis_store", 1'b0, 1'b1, 2'b00, 16'h0013, 16'h2222, 16'h0602, 4'd2, 0, 16'h0, 1'b0);
   endtask

   task automatic test_reset_mid;
      regWriteM = 1'b1; memWriteM = 1'b0; resultSrcM = 2'b01; aluResM = 16'h0080;
      writeDataM = 16'h0; PCPlus2M = 16'h0700; RdM = 4'd11; dif.dmem_ready = 1'b0;
      dif.dmem_rdata = 16'hF00D;
      repeat (2) begin @(posedge clk); @(negedge clk); end
      #1;
      total++;
      if (dif.dmem_req !== 1'b1) begin
         bad++; $display("FAIL rstmid_pre req got=%b exp=1", dif.dmem_req);
      end
      rst = 1'b0;
      #1;
      total++;
      if ({dif.dmem_req, dif.dmem_we, dif.dmem_addr, dif.dmem_wdata} !== 34'h0) begin
         bad++; $display("FAIL rstmid_bus got=%h exp=0",
            {dif.dmem_req, dif.dmem_we, dif.dmem_addr, dif.dmem_wdata});
      end
      total++;
      if ({regWriteW, resultSrcW, aluResW, readDataW, PCPlus2W, RdW, memFaultW} !== 56'h0) begin
         bad++; $display("FAIL rstmid_w got=%h exp=0",
            {regWriteW, resultSrcW, aluResW, readDataW, PCPlus2W, RdW, memFaultW});
      end
      regWriteM = 1'b0; resultSrcM = 2'b00; aluResM = 16'h0; PCPlus2M = 16'h0; RdM = 4'h0;
      @(negedge clk);
      rst = 1'b1;
      m_rw = 1'b0; m_src = 2'b00; m_alu = 16'h0; m_rdat = 16'h0; m_pc = 16'h0; m_rd = 4'h0;
      run_op("post_rst_alu", 1'b1, 1'b0, 2'b00, 16'h0abc, 16'h0, 16'h0702, 4'd12, 0, 16'h0, 1'b1);
   endtask

   task automatic test_random;
      logic [15:0] alu;
      for (int i = 0; i < 60; i++) begin
         alu = $urandom;
         alu[0] = ($urandom_range(0, 7) == 0);
         run_op("rand", 1'($urandom), ($urandom_range(0, 3) == 0), 2'($urandom_range(0, 3)),
                alu, 16'($urandom), 16'($urandom), 4'($urandom), $urandom_range(0, TO + 2),
                16'($urandom), 1'($urandom));
      end
   endtask

   initial begin
      test_reset();
      test_alu();
      test_load();
      test_store();
      test_timeout();
      test_misaligned();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/memory_stage.md
MEMORY_STAGE -- requirements
Module: memory_stage

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15, giving the max ACCESS cycles waited for dmem_ready.
REQ-002 SHALL have ports clk, in, 1, the single clock, rising edge.
REQ-003 SHALL have ports rst, in, 1, the asynchronous active-low reset.
REQ-004 SHALL have the E/M inputs regWriteM, memWriteM (in, 1); resultSrcM (in, 2); PCPlus2M, aluResM, writeDataM (in, 16); RdM (in, 4).
REQ-005 SHALL have the data-memory ports dmem_req, dmem_we (out, 1); dmem_addr, dmem_wdata (out, 16); dmem_rdata (in, 16); dmem_ready (in, 1).
REQ-006 SHALL have the hazard/status ports stallM (out, 1), which holds the upstream stages, and memFaultW (out, 1), a one-cycle fault pulse.
REQ-007 SHALL have the M/W outputs regWriteW (out, 1); resultSrcW (out, 2); aluResW, readDataW, PCPlus2W (out, 16); RdW (out, 4).

Function
REQ-008 SHALL treat the encoding resultSrcM 00=ALU, 01=load, 10=PC+2, 11=reserved (handled as ALU); a memory op is memWriteM=1 or resultSrcM=01.
REQ-009 SHALL, for a non-memory op in IDLE, load the M/W register at the next edge (latency 1) with stallM=0.
REQ-010 SHALL implement an FSM with states IDLE and ACCESS; it goes IDLE->ACCESS when a memory op is present, and ACCESS->IDLE on dmem_ready=1 or on timeout.
REQ-011 SHALL drive stallM = (IDLE and memory op) or (ACCESS and not dmem_ready and not timeout), combinationally.
REQ-012 SHALL, in ACCESS, drive dmem_req=1, dmem_addr=aluResM, dmem_we=memWriteM and dmem_wdata=writeDataM, held stable until completion; all four are 0 outside ACCESS.
REQ-013 SHALL complete the transfer on the edge where dmem_req and dmem_ready are both 1: readDataW<=dmem_rdata for loads, and the M/W register loads, giving a minimum memory-op latency of 2 cycles.
REQ-014 SHALL cause a store with memWriteM=1 and resultSrcM=01 to act as a store; readDataW SHALL keep its previous value.
REQ-015 SHALL load a bubble into M/W every cycle stallM=1: regWriteW=0, other W fields unchanged.
REQ-016 SHALL use a 4-bit-min wait counter that clears on entering ACCESS and increments each ACCESS cycle without ready; when it equals TIMEOUT-1 without ready, SHALL load a bubble, pulse memFaultW for 1 cycle, and return to IDLE with stallM=0.
REQ-017 SHALL treat an odd aluResM on a memory op as misaligned: no ACCESS entry, no dmem_req, memFaultW pulse, bubble, stallM=0 (latency 1).
REQ-018 SHALL give dmem_ready precedence over timeout when both occur in the same cycle (normal completion).
REQ-019 SHALL ignore dmem_ready while in IDLE.

Reset
REQ-020 SHALL, on rst=0 and asynchronously, set state=IDLE, counter=0, dmem_req=dmem_we=0, dmem_addr=dmem_wdata=0, all W outputs=0 and memFaultW=0.
REQ-021 SHALL abort a transfer on reset mid-ACCESS, dropping dmem_req immediately; no W update SHALL occur for that op.
REQ-022 SHALL resume normal operation from IDLE on the first rising edge after rst returns to 1.

Structure
REQ-023 SHALL place the state enum, the resultSrc encodings (RES_ALU, RES_MEM, RES_PC) and the TIMEOUT default in the shared package mem_pkg.
REQ-024 SHALL implement the M/W pipeline register as the sub-module mw_reg, with load and bubble controls; the FSM and handshake SHALL stay in memory_stage.

Verification
REQ-025 SHALL cover this case: ALU op aluResM=0x001F, RdM=2, regWriteM=1 -> next cycle aluResW=0x001F, RdW=2, regWriteW=1, stallM never high.
REQ-026 SHALL cover this case: load aluResM=0x0040 with dmem_ready high 3 cycles after req and dmem_rdata=0xBEEF -> stallM high 4 cycles, a bubble for each, then readDataW=0xBEEF, regWriteW=1.
REQ-027 SHALL cover this case: store aluResM=0x0010, writeDataM=0x1234, ready at first ACCESS cycle -> dmem_we=1, addr=0x0010, wdata=0x1234 for exactly 1 cycle, then regWriteW=0.
REQ-028 SHALL cover this case: load with dmem_ready held low and TIMEOUT=15 -> memFaultW pulse after 15 ACCESS cycles, stallM drops, regWriteW=0.
REQ-029 SHALL cover this case: load at aluResM=0x0011 -> no dmem_req, memFaultW=1 next cycle, no stall.
REQ-030 SHALL cover this case: rst=0 pulsed on the 2nd ACCESS cycle -> dmem_req=0 within the same cycle, W outputs 0, FSM IDLE after release.
